// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache-side request ports and the shared memory-side port.
// slave: the arbiter's view. master: the surrounding controllers and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              p0_valid, p1_valid;
  logic              p0_rw, p1_rw;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_lock, p1_lock;
  logic              p0_ready, p1_ready;
  logic [DATA_W-1:0] p_rdata;
  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_valid, p1_valid, p0_rw, p1_rw, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_lock, p1_lock, mem_ready, mem_rdata,
    output p0_ready, p1_ready, p_rdata, mem_valid, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output p0_valid, p1_valid, p0_rw, p1_rw, p0_addr, p1_addr,
           p0_wdata, p1_wdata, p0_lock, p1_lock, mem_ready, mem_rdata,
    input  p0_ready, p1_ready, p_rdata, mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the D-cache (port 0) and
// I-cache (port 1); a per-port lock keeps write-back + refill pairs atomic.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t          state, state_nx;
  logic            owner, owner_nx;
  logic            last_grant, last_nx;
  logic            grant, gnt_port, done;
  logic            mem_valid_q;
  req_t            mem_req;
  req_t [1:0]      req;
  logic [1:0]      valid, lock;

  assign valid  = {bus.p1_valid, bus.p0_valid};
  assign lock   = {bus.p1_lock, bus.p0_lock};
  assign req[0] = {bus.p0_rw, bus.p0_addr, bus.p0_wdata};
  assign req[1] = {bus.p1_rw, bus.p1_addr, bus.p1_wdata};

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_grant;
    grant    = 1'b0;
    gnt_port = owner;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (|valid) begin
          // on a tie the port that did not win last time goes first
          gnt_port = (&valid) ? ~last_grant : valid[1];
          grant    = 1'b1;
          owner_nx = gnt_port;
          last_nx  = gnt_port;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          done     = 1'b1;
          state_nx = lock[owner] ? HOLD : IDLE;
        end
      end
      HOLD: begin
        // only the lock owner may be served; round-robin history is untouched
        if (valid[owner]) begin
          grant    = 1'b1;
          state_nx = BUSY;
        end else if (!lock[owner]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_req     <= '0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last_grant  <= last_nx;
      mem_valid_q <= grant | (mem_valid_q & ~done);
      if (grant) mem_req <= req[gnt_port];
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rw    = mem_req.rw;
  assign bus.mem_addr  = mem_req.addr;
  assign bus.mem_wdata = mem_req.wdata;
  assign bus.p0_ready  = done & ~owner & ~rst;
  assign bus.p1_ready  = done &  owner & ~rst;
  assign bus.p_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level grant model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory responder: completes mem_lat cycles after mem_valid is first seen
  int               mem_lat = 3;
  int               wcnt = 0;
  logic [DW-1:0]    resp_data = 64'h0123_4567_89AB_CDEF;
  logic             mem_ready_r = 1'b0;
  logic [DW-1:0]    mem_rdata_r = '0;
  assign ifc.mem_ready = mem_ready_r;
  assign ifc.mem_rdata = mem_rdata_r;

  always @(posedge clk) begin
    #2;
    if (rst || !ifc.mem_valid) begin
      wcnt = 0; mem_ready_r = 1'b0; mem_rdata_r = ~resp_data;
    end else if (wcnt == mem_lat) begin
      wcnt = 0; mem_ready_r = 1'b1; mem_rdata_r = resp_data;
    end else begin
      wcnt++; mem_ready_r = 1'b0; mem_rdata_r = ~resp_data;
    end
  end

  // transaction-level model: who holds the memory port and what it asked for
  bit            mdl_ok = 1'b0;
  bit            m_busy = 1'b0, m_hold = 1'b0;
  int            m_own = 0, m_last = 1, pick;
  logic          m_rw = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  bit [1:0]      vl, lk;

  always @(posedge clk) begin
    cyc++;
    vl = {ifc.p1_valid, ifc.p0_valid};
    lk = {ifc.p1_lock, ifc.p0_lock};
    if (rst) begin
      m_busy = 0; m_hold = 0; m_own = 0; m_last = 1;
      m_rw = 0; m_addr = '0; m_wd = '0; mdl_ok = 1;
    end else if (mdl_ok) begin
      if (m_busy) begin
        if (ifc.mem_ready) begin m_busy = 0; m_hold = lk[m_own]; end
      end else begin
        pick = -1;
        if (m_hold) begin
          if (vl[m_own]) pick = m_own;
          else if (!lk[m_own]) m_hold = 0;
        end else if (vl == 2'b11) pick = 1 - m_last;
        else if (vl[0]) pick = 0;
        else if (vl[1]) pick = 1;
        if (pick >= 0) begin
          if (!m_hold) m_last = pick;
          m_own  = pick;
          m_busy = 1;
          m_rw   = pick ? ifc.p1_rw : ifc.p0_rw;
          m_addr = pick ? ifc.p1_addr : ifc.p0_addr;
          m_wd   = pick ? ifc.p1_wdata : ifc.p0_wdata;
        end
      end
    end
  end

  typedef struct { int c; logic rw; logic [AW-1:0] addr; } gnt_t;
  gnt_t glog[$];
  logic prev_mv = 1'b0;

  always @(negedge clk) begin
    if (ifc.mem_valid && !prev_mv) glog.push_back('{cyc, ifc.mem_rw, ifc.mem_addr});
    prev_mv = ifc.mem_valid;
    if (mdl_ok) begin
      chk("mdl_mem_valid", ifc.mem_valid, m_busy);
      if (m_busy) begin
        chk("mdl_mem_rw", ifc.mem_rw, m_rw);
        chk("mdl_mem_addr", ifc.mem_addr, m_addr);
        chk("mdl_mem_wdata", ifc.mem_wdata, m_wd);
      end
      chk("mdl_p0_ready", ifc.p0_ready, m_busy && ifc.mem_ready && m_own == 0 && !rst);
      chk("mdl_p1_ready", ifc.p1_ready, m_busy && ifc.mem_ready && m_own == 1 && !rst);
      if (ifc.p0_ready || ifc.p1_ready) chk("mdl_rdata", ifc.p_rdata, ifc.mem_rdata);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input int p, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? ifc.p0_ready : ifc.p1_ready;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: no ready on port %0d within 60 cycles", nm, p);
    end
  endtask

  int drop_c;

  initial begin
    ifc.p0_valid = 0; ifc.p1_valid = 0; ifc.p0_rw = 0; ifc.p1_rw = 0;
    ifc.p0_addr = '0; ifc.p1_addr = '0; ifc.p0_wdata = '0; ifc.p1_wdata = '0;
    ifc.p0_lock = 0; ifc.p1_lock = 0;
    rst = 1;
    repeat (2) tick;
    @(negedge clk);
    chk("rst_mem_valid", ifc.mem_valid, 0);
    chk("rst_mem_addr", ifc.mem_addr, 0);
    chk("rst_p0_ready", ifc.p0_ready, 0);
    chk("rst_p1_ready", ifc.p1_ready, 0);

    // single read: request in cycle 1, issue in 2, complete in 5
    tick; rst = 0;
    resp_data = 64'hDEADBEEF_CAFEF00D; mem_lat = 3;
    ifc.p0_valid = 1; ifc.p0_rw = 0; ifc.p0_addr = 32'h1000;
    @(negedge clk); chk("t1_no_issue_c1", ifc.mem_valid, 0);
    tick; @(negedge clk);
    chk("t1_mem_valid_c2", ifc.mem_valid, 1);
    chk("t1_mem_addr_c2", ifc.mem_addr, 32'h1000);
    repeat (3) tick;
    @(negedge clk);
    chk("t1_p0_ready_c5", ifc.p0_ready, 1);
    chk("t1_rdata_c5", ifc.p_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("t1_p1_ready_c5", ifc.p1_ready, 0);
    tick; ifc.p0_valid = 0;
    @(negedge clk); chk("t1_mem_valid_c6", ifc.mem_valid, 0);

    // fairness from a fresh reset: both ports always requesting
    tick; rst = 1;
    tick; rst = 0;
    resp_data = 64'h1111_2222_3333_4444;
    glog.delete();
    ifc.p0_addr = 32'hA000; ifc.p1_addr = 32'hB000;
    ifc.p0_valid = 1; ifc.p1_valid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (glog.size() >= 4 && ifc.p1_ready) break;
    end
    tick; ifc.p0_valid = 0; ifc.p1_valid = 0;
    chk("t2_grants", glog.size(), 4);
    if (glog.size() >= 4) begin
      chk("t2_g0", glog[0].addr, 32'hA000);
      chk("t2_g1", glog[1].addr, 32'hB000);
      chk("t2_g2", glog[2].addr, 32'hA000);
      chk("t2_g3", glog[3].addr, 32'hB000);
      for (int i = 0; i < 3; i++) chk("t2_spacing", glog[i+1].c - glog[i].c, 5);
    end

    // locked write-back then refill; p1 waits throughout
    tick;
    glog.delete();
    ifc.p0_rw = 1; ifc.p0_lock = 1; ifc.p0_addr = 32'h2000; ifc.p0_wdata = 64'h5555_AAAA_5555_AAAA;
    ifc.p0_valid = 1; ifc.p1_valid = 1;
    wait_rdy(0, "t3_wb");
    tick; ifc.p0_rw = 0; ifc.p0_addr = 32'h3000; ifc.p0_lock = 0;
    wait_rdy(0, "t3_refill");
    tick; ifc.p0_valid = 0;
    wait_rdy(1, "t3_p1");
    tick; ifc.p1_valid = 0;
    chk("t3_grants", glog.size(), 3);
    if (glog.size() >= 3) begin
      chk("t3_g0_addr", glog[0].addr, 32'h2000);
      chk("t3_g0_rw", glog[0].rw, 1);
      chk("t3_g1_addr", glog[1].addr, 32'h3000);
      chk("t3_g2_addr", glog[2].addr, 32'hB000);
    end

    // lock released with no follow-up request
    tick;
    glog.delete();
    ifc.p0_lock = 1; ifc.p0_addr = 32'h4000; ifc.p0_valid = 1; ifc.p1_valid = 1;
    wait_rdy(0, "t4_p0");
    tick; ifc.p0_valid = 0; ifc.p0_lock = 0; drop_c = cyc;
    wait_rdy(1, "t4_p1");
    tick; ifc.p1_valid = 0;
    chk("t4_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("t4_g0_addr", glog[0].addr, 32'h4000);
      chk("t4_g1_addr", glog[1].addr, 32'hB000);
      chk("t4_p1_delay", glog[1].c - drop_c, 2);
    end

    // requester payload changes mid-transaction are ignored
    tick; ifc.p0_addr = 32'h1000; ifc.p0_valid = 1;
    tick; ifc.p0_addr = 32'h5000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_addr_frozen", ifc.mem_addr, 32'h1000);
      if (ifc.p0_ready) break;
      tick;
    end
    tick; ifc.p0_valid = 0;

    // reset while busy aborts with no ready; tie afterwards goes to p0
    tick; mem_lat = 10;
    ifc.p0_rw = 1; ifc.p0_addr = 32'h6000; ifc.p0_wdata = 64'hABCD; ifc.p0_valid = 1;
    tick;
    @(negedge clk); chk("t6_busy", ifc.mem_valid, 1);
    tick; rst = 1;
    @(negedge clk); chk("t6_rst_p0_ready", ifc.p0_ready, 0);
    tick; rst = 0; ifc.p0_valid = 0; ifc.p0_rw = 0;
    @(negedge clk);
    chk("t6_mem_valid", ifc.mem_valid, 0);
    chk("t6_mem_rw", ifc.mem_rw, 0);
    chk("t6_mem_addr", ifc.mem_addr, 0);
    chk("t6_mem_wdata", ifc.mem_wdata, 0);
    tick; mem_lat = 3;
    glog.delete();
    ifc.p0_addr = 32'h7000; ifc.p0_valid = 1; ifc.p1_valid = 1;
    wait_rdy(0, "t6_p0");
    tick; ifc.p0_valid = 0;
    wait_rdy(1, "t6_p1");
    tick; ifc.p1_valid = 0;
    chk("t6_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("t6_g0_addr", glog[0].addr, 32'h7000);
      chk("t6_g1_addr", glog[1].addr, 32'hB000);
    end

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single backing-memory request/response interface between two cache controllers (port 0: data cache, port 1: instruction cache). Requests are registered onto the memory side with round-robin fairness. Each grant stays in place until the memory signals completion, and an optional per-port lock keeps a write-back plus refill pair atomic. Sits between the cache controllers' memory interfaces and the memory model or bus.

## Interface
- ADDR_W, 32, byte address width (cache line address, low 3 bits zero)
- DATA_W, 64, line width (two 32-bit words)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- p0_valid / p1_valid  in  1  request pending; held until that port's ready
- p0_rw / p1_rw  in  1  1 = write line, 0 = read line
- p0_addr / p1_addr  in  ADDR_W  line address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_lock / p1_lock  in  1  keep grant after this transaction completes
- p0_ready / p1_ready  out  1  one-cycle completion pulse to that port
- p_rdata  out  DATA_W  read data, shared; valid only with a ready pulse
- mem_valid  out  1  registered request to memory
- mem_rw  out  1  registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_ready  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ready

## Operation
- State register: IDLE, BUSY, HOLD, plus owner (1 bit) and last_grant (1 bit).
- IDLE:
  - Neither valid: stay.
  - One valid: grant it.
  - Both valid: grant the port ≠ last_grant.
  - On grant: latch that port's rw/addr/wdata into the mem_* registers, set mem_valid=1, owner=port, last_grant=port, go to BUSY.
- BUSY:
  - mem_* registers are frozen; requester input changes are ignored.
  - mem_ready=1: pN_ready=1 for the owner only (combinational, same cycle), and p_rdata=mem_rdata. mem_valid clears at the next edge.
  - Next state on completion: HOLD if owner's lock=1 in the mem_ready cycle, else IDLE.
- HOLD:
  - The other port is never granted.
  - Owner valid=1: latch owner request, mem_valid=1, go to BUSY; last_grant unchanged.
  - Owner lock=0 and valid=0: go to IDLE.
  - Owner lock=0 and valid=1: still served from HOLD, then IDLE after completion unless lock reasserts.
- p_rdata = mem_rdata at all times; consumers qualify it with their ready.
- Requesters must hold valid and payload stable until ready. Dropping valid in BUSY does not abort; the completion pulse is still issued.
- A lock held indefinitely starves the other port by design. Controllers must release lock after the refill.

## Timing
- Reset (rst=1 at an edge): state=IDLE, mem_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0, last_grant=1 (so port 0 wins the first tie), owner=0. p0_ready=p1_ready=0 while in reset.
- Reset mid-transaction aborts the transaction: mem_valid=0 after the edge, and no ready pulse is issued. The memory side must be reset concurrently.
- Request latency: pN_valid high in cycle N → mem_valid high in cycle N+1.
- Completion latency: mem_ready in cycle M → pN_ready in cycle M (zero added latency).
- Back-to-back (no lock): the earliest next mem_valid is M+2, because IDLE is evaluated in M+1. The HOLD path gives the same M+2.
- mem_ready while in IDLE or HOLD is ignored; no ready pulse is generated.
- mem_ready in the same cycle the request is issued is impossible, since mem_valid rises only after the edge.
- A new request arriving at the owner port in the same cycle as its ready is a new transaction. It is arbitrated in the following cycle.

## Test plan
- Single read: p0_valid=1, rw=0, addr=0x0000_1000 at cycle 1. Required: mem_valid=1, mem_addr=0x1000 at cycle 2. Memory drives mem_ready=1, mem_rdata=0xDEADBEEF_CAFEF00D at cycle 5. Required: p0_ready=1 and p_rdata equal to that value at cycle 5, p1_ready=0, and mem_valid=0 at cycle 6.
- Tie and fairness: p0 and p1 held valid continuously, each completion 3 cycles after mem_valid. Required grant order: p0, p1, p0, p1. Required mem_valid rise spacing: 5 cycles.
- Locked write-back/refill: p0 write with lock=1 to 0x2000, p1 valid throughout. After p0 completes, p0 issues a read of 0x3000 with lock=0. Required: the 0x3000 read is granted before any p1 grant, and p1 is served next.
- Lock release without request: p0 lock=1 completes, then p0 drops lock and valid in the next cycle while p1 is valid. Required: HOLD→IDLE, then p1 mem_valid exactly 2 cycles after the lock drop.
- Payload stability: during BUSY, change p0_addr from 0x1000 to 0x5000. Required: mem_addr stays 0x1000 until completion.
- Reset mid-BUSY: assert rst for one cycle while mem_valid=1. Required: mem_valid=0 and all mem_* outputs zero after the edge, no ready pulse, and a p1-vs-p0 tie afterward is won by p0.
